diferential_cfg_loader: RTL

//  Serial configuration loader and run sequencer for the muxpga cell array.
//  - Loads one CFG_W-bit config word per cell over a 1-bit serial input, so each cell gets its own config

---
 rtl/diferential_cfg_loader_if.sv | 26 ++
 rtl/diferential_cfg_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/diferential_cfg_loader_if.sv
// Serial config loader bus: load-control inputs plus committed-config outputs.
`timescale 1ns/1ps

interface diferential_cfg_loader_if #(
  parameter int unsigned TOTAL = 36
);
  logic             start;
  logic             din;
  logic             din_valid;
  logic [TOTAL-1:0] cfg_bus;
  logic             cell_run;
  logic             busy;
  logic             cfg_err;

  // Pin-side driver of the loader
  modport master (
    output start, din, din_valid,
    input  cfg_bus, cell_run, busy, cfg_err
  );

  // Loader itself
  modport slave (
    input  start, din, din_valid,
    output cfg_bus, cell_run, busy, cfg_err
  );
endinterface

// File: rtl/diferential_cfg_loader.sv
// Serial configuration loader and run sequencer for the muxpga cell array.
// Shifts in one CFG_W-bit word per cell MSB-first, commits the whole payload
// into cfg_bus in one edge, then enables the array via cell_run.
// Optional macro DIFERENTIAL_CFG_PARITY_EN adds a trailing even-parity bit
// and an ERR state; without it cfg_err is tied low.
`timescale 1ns/1ps

module diferential_cfg_loader #(
  parameter int unsigned NCELLS = 9,
  parameter int unsigned CFG_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  diferential_cfg_loader_if.slave bus
);

  localparam int unsigned TOTAL = NCELLS * CFG_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

`ifdef DIFERENTIAL_CFG_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PAR    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_COMMIT = 3'd3,
    ST_RUN    = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [TOTAL-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOTAL-1:0] cfg_q, cfg_d;
  logic             run_q, run_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // Next-state, datapath and next-output decode; start overrides everything
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    if (bus.start) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bus.din_valid) begin
            sr_d  = {sr_q[TOTAL-2:0], bus.din};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
`ifdef DIFERENTIAL_CFG_PARITY_EN
              state_d = ST_PAR;
`else
              state_d = ST_COMMIT;
`endif
            end
          end
        end
`ifdef DIFERENTIAL_CFG_PARITY_EN
        ST_PAR: begin
          if (bus.din_valid) begin
            state_d = (^{sr_q, bus.din}) ? ST_ERR : ST_COMMIT;
          end
        end
`endif
        ST_COMMIT: begin
          cfg_d   = sr_q;
          state_d = ST_RUN;
        end
        default: ;
      endcase
    end
    // Outputs are registered from the next state so they track the state register
    run_d  = (state_d == ST_RUN);
`ifdef DIFERENTIAL_CFG_PARITY_EN
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_PAR) || (state_d == ST_COMMIT);
    err_d  = (state_d == ST_ERR);
`else
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_COMMIT);
    err_d  = 1'b0;
`endif
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_bus  = cfg_q;
  assign bus.cell_run = run_q;
  assign bus.busy     = busy_q;
`ifdef DIFERENTIAL_CFG_PARITY_EN
  assign bus.cfg_err  = err_q;
`else
  assign bus.cfg_err  = 1'b0;
`endif

endmodule
